pipe_reg_chain: RTL and testbench

- Parametrised replacement for the fixed IF_ID/ID_EX/EX_MEM/MEM_WB register modules of the 5-stage core.
- One instance holds DEPTH pipeline registers, each carrying a valid bit, a control field and a data payload.
- Provides per-stage stall with automatic bubble insertion, per-stage flush, an input-ready handshake, and flat taps of every stage for the forwarding and hazard logic.

---
 rtl/pipe_reg_chain.sv | 149 ++++++++++++++
 tb/tb_pipe_reg_chain.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage pipeline register chain: per-stage stall/flush, automatic bubbles, stage taps; DEPTH-1 edges input to out_*.
// Any stall at or beyond stage i holds stage i and drops in_ready; PIPE_REG_CHAIN_PERF_EN adds saturating perf counters.
module pipe_reg_chain #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 8,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [CTRL_W-1:0]         in_ctrl,
    output logic                      in_ready,
    input  logic [DEPTH-1:0]          stall,
    input  logic [DEPTH-1:0]          flush,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [DEPTH-1:0]          stage_valid,
    output logic [DEPTH*WIDTH-1:0]    stage_data_flat,
    output logic [DEPTH*CTRL_W-1:0]   stage_ctrl_flat,
    output logic [OCC_W-1:0]          occupancy,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               bubble_count,
    output logic [31:0]               flush_count
);

    logic [DEPTH-1:0]  r_valid;
    logic [CTRL_W-1:0] r_ctrl [DEPTH];
    logic [WIDTH-1:0]  r_data [DEPTH];

    logic [DEPTH-1:0]  w_hold;
    logic [DEPTH-1:0]  w_bubble;
    logic [DEPTH-1:0]  w_src_valid;
    logic [CTRL_W-1:0] w_src_ctrl [DEPTH];
    logic [WIDTH-1:0]  w_src_data [DEPTH];

    // A stage may only move when nothing at or beyond it is stalled; the first
    // moving stage behind a held one receives a bubble.
    always_comb begin
        w_hold   = '0;
        w_bubble = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hold[i] = |(stall >> i);
        end
        for (int i = 1; i < DEPTH; i++) begin
            w_bubble[i] = w_hold[i-1] & ~w_hold[i] & ~flush[i];
        end
    end

    always_comb begin
        w_src_valid[0] = in_valid;
        w_src_ctrl[0]  = in_valid ? in_ctrl : '0;
        w_src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_valid[i] = r_valid[i-1];
            w_src_ctrl[i]  = r_ctrl[i-1];
            w_src_data[i]  = r_data[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush[i]) begin
                    r_valid[i] <= 1'b0;
                    r_ctrl[i]  <= '0;
                end else if (!w_hold[i]) begin
                    if (w_bubble[i]) begin
                        r_valid[i] <= 1'b0;
                        r_ctrl[i]  <= '0;
                    end else begin
                        r_valid[i] <= w_src_valid[i];
                        r_ctrl[i]  <= w_src_ctrl[i];
                    end
                    r_data[i] <= w_src_data[i];
                end
            end
        end
    end

    assign in_ready    = ~w_hold[0];
    assign out_valid   = r_valid[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign out_ctrl    = r_ctrl[DEPTH-1];
    assign stage_valid = r_valid;

    always_comb begin
        stage_data_flat = '0;
        stage_ctrl_flat = '0;
        occupancy       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_data_flat[i*WIDTH +: WIDTH]   = r_data[i];
            stage_ctrl_flat[i*CTRL_W +: CTRL_W] = r_ctrl[i];
            occupancy = occupancy + OCC_W'(r_valid[i]);
        end
    end

`ifdef PIPE_REG_CHAIN_PERF_EN
    logic [31:0]      r_stall_cycles;
    logic [31:0]      r_bubble_count;
    logic [31:0]      r_flush_count;
    logic [OCC_W-1:0] w_bubble_n;
    logic [OCC_W-1:0] w_kill_n;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        w_bubble_n = '0;
        w_kill_n   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_bubble_n = w_bubble_n + OCC_W'(w_bubble[i]);
            w_kill_n   = w_kill_n + OCC_W'(flush[i] & r_valid[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_bubble_count <= '0;
            r_flush_count  <= '0;
        end else begin
            r_stall_cycles <= sat_add(r_stall_cycles, {31'd0, |stall});
            r_bubble_count <= sat_add(r_bubble_count, 32'(w_bubble_n));
            r_flush_count  <= sat_add(r_flush_count, 32'(w_kill_n));
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign bubble_count = r_bubble_count;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = 32'd0;
    assign bubble_count = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed scenarios plus random traffic against a stage-array reference model.
module tb_pipe_reg_chain;
    localparam int D = 4;
    localparam int W = 64;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [C-1:0]   in_ctrl;
    logic           in_ready;
    logic [D-1:0]   stall;
    logic [D-1:0]   flush;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [C-1:0]   out_ctrl;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data_flat;
    logic [D*C-1:0] stage_ctrl_flat;
    logic [2:0]     occupancy;
    logic [31:0]    stall_cycles;
    logic [31:0]    bubble_count;
    logic [31:0]    flush_count;

    int checks   = 0;
    int failures = 0;

    logic         m_v [D];
    logic [C-1:0] m_c [D];
    logic [W-1:0] m_d [D];
    longint       m_stall;
    longint       m_bub;
    longint       m_fl;

    always #5 clk = ~clk;

    pipe_reg_chain #(.DEPTH(D), .WIDTH(W), .CTRL_W(C)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ctrl(out_ctrl),
        .stage_valid(stage_valid), .stage_data_flat(stage_data_flat),
        .stage_ctrl_flat(stage_ctrl_flat), .occupancy(occupancy),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_v[i] = 1'b0;
            m_c[i] = '0;
            m_d[i] = '0;
        end
        m_stall = 0;
        m_bub   = 0;
        m_fl    = 0;
    endtask

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic         nv [D];
        logic [C-1:0] nc [D];
        logic [W-1:0] nd [D];
        bit           frozen [D];
        frozen[D-1] = stall[D-1];
        for (int i = D - 2; i >= 0; i--) frozen[i] = frozen[i+1] || stall[i];
        if (stall != 0) m_stall = sat32(m_stall + 1);
        for (int i = 0; i < D; i++) begin
            nv[i] = m_v[i];
            nc[i] = m_c[i];
            nd[i] = m_d[i];
            if (flush[i]) begin
                if (m_v[i]) m_fl = sat32(m_fl + 1);
                nv[i] = 1'b0;
                nc[i] = '0;
            end else if (frozen[i]) begin
                nv[i] = m_v[i];
            end else if (i == 0) begin
                nv[0] = in_valid;
                nc[0] = in_valid ? in_ctrl : '0;
                nd[0] = in_data;
            end else if (frozen[i-1]) begin
                nv[i] = 1'b0;
                nc[i] = '0;
                nd[i] = m_d[i-1];
                m_bub = sat32(m_bub + 1);
            end else begin
                nv[i] = m_v[i-1];
                nc[i] = m_c[i-1];
                nd[i] = m_d[i-1];
            end
        end
        for (int i = 0; i < D; i++) begin
            m_v[i] = nv[i];
            m_c[i] = nc[i];
            m_d[i] = nd[i];
        end
    endtask

    task automatic compare_all(input string tag);
        logic [D*W-1:0] ed;
        logic [D*C-1:0] ec;
        logic [D-1:0]   ev;
        int             occ;
        occ = 0;
        for (int i = 0; i < D; i++) begin
            ev[i]         = m_v[i];
            ed[i*W +: W]  = m_d[i];
            ec[i*C +: C]  = m_c[i];
            occ           = occ + int'(m_v[i]);
        end
        check({tag, ".stage_valid"}, stage_valid, ev);
        check({tag, ".stage_data"}, stage_data_flat, ed);
        check({tag, ".stage_ctrl"}, stage_ctrl_flat, ec);
        check({tag, ".out_valid"}, out_valid, m_v[D-1]);
        check({tag, ".out_data"}, out_data, m_d[D-1]);
        check({tag, ".out_ctrl"}, out_ctrl, m_c[D-1]);
        check({tag, ".in_ready"}, in_ready, (stall == 0));
        check({tag, ".occupancy"}, occupancy, occ);
`ifdef PIPE_REG_CHAIN_PERF_EN
        check({tag, ".stall_cycles"}, stall_cycles, m_stall);
        check({tag, ".bubble_count"}, bubble_count, m_bub);
        check({tag, ".flush_count"}, flush_count, m_fl);
`else
        check({tag, ".stall_cycles"}, stall_cycles, 0);
        check({tag, ".bubble_count"}, bubble_count, 0);
        check({tag, ".flush_count"}, flush_count, 0);
`endif
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic [C-1:0] c,
                         input logic [D-1:0] st, input logic [D-1:0] fl);
        in_valid = iv;
        in_data  = d;
        in_ctrl  = c;
        stall    = st;
        flush    = fl;
        #1;
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        drive(1'b0, '0, '0, '0, '0);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] rs;
        logic [D-1:0] rf;
        reset = 1'b1;
        model_reset();
        drive(1'b0, '0, '0, '0, '0);
        compare_all("reset");
        check("reset.in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Plain stream: three cycles of latency after acceptance.
        drive(1'b1, 64'h10, 8'h81, '0, '0); tick("strm");
        drive(1'b1, 64'h14, 8'h81, '0, '0); tick("strm");
        drive(1'b1, 64'h18, 8'h81, '0, '0); tick("strm");
        check("strm.occ_peak", occupancy, 3);
        check("strm.in_ready", in_ready, 1'b1);
        idle(1, "strm");
        check("strm.out0", {out_valid, out_ctrl, out_data}, {1'b1, 8'h81, 64'h10});
        idle(1, "strm");
        check("strm.out1", {out_valid, out_data}, {1'b1, 64'h14});
        idle(1, "strm");
        check("strm.out2", {out_valid, out_data}, {1'b1, 64'h18});
        idle(1, "strm");
        check("strm.drained", occupancy, 0);

        // Load-use stall on stage 1 with B resident there.
        drive(1'b1, 64'hA0, 8'h11, '0, '0); tick("lu");
        drive(1'b1, 64'hB0, 8'h22, '0, '0); tick("lu");
        drive(1'b1, 64'hC0, 8'h33, '0, '0); tick("lu");
        drive(1'b0, '0, '0, 4'b0010, '0);
        check("lu.in_ready_low", in_ready, 1'b0);
        tick("lu");
        check("lu.bubble_ctrl", stage_ctrl_flat[2*C +: C], 8'h00);
        check("lu.bubble_valid", stage_valid, 4'b1011);
        check("lu.outA", {out_valid, out_data}, {1'b1, 64'hA0});
        idle(1, "lu");
        check("lu.out_bubble", out_valid, 1'b0);
        idle(1, "lu");
        check("lu.outB", {out_valid, out_data}, {1'b1, 64'hB0});
        idle(1, "lu");
        check("lu.outC", {out_valid, out_data}, {1'b1, 64'hC0});
        idle(2, "lu");

        // Branch kill: stall[1] with flush[1:0]; stage 2 takes a bubble, its entry moves on.
        drive(1'b1, 64'h100, 8'h44, '0, '0); tick("bk");
        drive(1'b1, 64'h104, 8'h55, '0, '0); tick("bk");
        drive(1'b1, 64'h108, 8'h66, '0, '0); tick("bk");
        check("bk.occ_before", occupancy, 3);
        drive(1'b0, '0, '0, 4'b0010, 4'b0011);
        tick("bk");
        check("bk.stage_valid", stage_valid, 4'b1000);
        check("bk.ctrl01", stage_ctrl_flat[2*C-1:0], 16'h0000);
        check("bk.occ_after", occupancy, 1);
        idle(2, "bk");

        // Output stall held three cycles with a full pipe.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'h40 + 64'(k), 8'h70 + 8'(k), '0, '0);
            tick("ost");
        end
        drive(1'b1, 64'h99, 8'h09, 4'b1000, '0);
        check("ost.in_ready", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick("ost");
            check("ost.out_const", {out_valid, out_data}, {1'b1, 64'h40});
            check("ost.full", stage_valid, 4'b1111);
        end
        idle(5, "ost");

        // Asynchronous reset between edges, then a fresh entry.
        drive(1'b1, 64'h200, 8'h12, '0, '0); tick("rst");
        drive(1'b1, 64'h204, 8'h13, '0, '0); tick("rst");
        #2 reset = 1'b1;
        #1;
        check("rst.valid0", stage_valid, 4'b0000);
        check("rst.out_ctrl0", out_ctrl, 8'h00);
        check("rst.occ0", occupancy, 0);
        model_reset();
        compare_all("rst.now");
        #1 reset = 1'b0;
        drive(1'b1, 64'h300, 8'h5A, '0, '0); tick("rst");
        idle(2, "rst");
        check("rst.not_yet", out_valid, 1'b0);
        idle(1, "rst");
        check("rst.first_out", {out_valid, out_ctrl, out_data}, {1'b1, 8'h5A, 64'h300});

        // Counter scenario: 2 stall cycles, 1 bubble, 2 valid stages flushed.
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        drive(1'b1, 64'h1, 8'h01, '0, '0); tick("perf");
        drive(1'b1, 64'h2, 8'h02, '0, '0); tick("perf");
        drive(1'b0, '0, '0, 4'b1000, '0); tick("perf");
        drive(1'b0, '0, '0, 4'b0010, '0); tick("perf");
        drive(1'b0, '0, '0, '0, 4'b1111); tick("perf");
`ifdef PIPE_REG_CHAIN_PERF_EN
        check("perf.stall_cycles", stall_cycles, 2);
        check("perf.bubble_count", bubble_count, 1);
        check("perf.flush_count", flush_count, 2);
`else
        check("perf.stall_cycles", stall_cycles, 0);
        check("perf.bubble_count", bubble_count, 0);
        check("perf.flush_count", flush_count, 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < D; b++) begin
                rs[b] = ($urandom_range(0, 7) == 0);
                rf[b] = ($urandom_range(0, 9) == 0);
            end
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom), rs, rf);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
